// File: rtl/dds_top.sv
// DDS core: tuning-word phase accumulator driving a selectable waveform generator
// (sine, square, saw, triangle, reverse saw). Define DDS_PHASE_OFFSET_EN to add phase_off.

module dds_wave #(
  parameter int n = 14,
  parameter int m = 12
) (
  input  logic [n-1:0] p_i,
  input  logic [2:0]   sel_i,
  output logic [m-1:0] wave_o
);
  localparam int SH = 2*n - 4 - (m - 1);
  localparam logic [2*n-3:0] AMP_MAX = (2*n-2)'((1 << (m-1)) - 1);
  localparam logic [m-1:0]   MID     = {1'b1, {(m-1){1'b0}}};

  logic         h;
  logic [n-2:0] x, xc;
  logic [2*n-3:0] y, ysh;
  logic [m-2:0] amp;
  logic [m-1:0] sine, tri_t;

  assign h  = p_i[n-1];
  assign x  = p_i[n-2:0];
  // 2^(n-1)-1-x is just the bitwise complement of x in n-1 bits
  assign xc = ~x;
  assign y  = {{(n-1){1'b0}}, x} * {{(n-1){1'b0}}, xc};
  assign ysh = y >> SH;
  assign amp = (ysh > AMP_MAX) ? AMP_MAX[m-2:0] : ysh[m-2:0];
  assign sine  = h ? (MID - {1'b0, amp}) : (MID + {1'b0, amp});
  assign tri_t = p_i[n-2 -: m];

  always_comb begin
    wave_o = MID;
    case (sel_i)
      3'b000:  wave_o = sine;
      3'b001:  wave_o = h ? '0 : '1;
      3'b010:  wave_o = p_i[n-1 -: m];
      3'b011:  wave_o = h ? ~tri_t : tri_t;
      3'b100:  wave_o = ~p_i[n-1 -: m];
      default: wave_o = MID;
    endcase
  end
endmodule

module dds_top #(
  parameter int tune = 16,
  parameter int n    = 14,
  parameter int m    = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [tune-1:0] tuningW,
  input  logic [2:0]      sel,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [n-1:0]    phase_off,
`endif
  output logic [m-1:0]    OUT
);
  logic [tune-1:0] acc_q, acc_d;
  logic [m-1:0]    out_q, out_d;
  logic [n-1:0]    phase;

`ifdef DDS_PHASE_OFFSET_EN
  assign phase = acc_q[tune-1 -: n] + phase_off;
`else
  assign phase = acc_q[tune-1 -: n];
`endif

  // Sample is formed from the pre-edge phase, so OUT trails acc by one cycle.
  dds_wave #(.n(n), .m(m)) u_wave (
    .p_i    (phase),
    .sel_i  (sel),
    .wave_o (out_d)
  );

  assign acc_d = acc_q + tuningW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign OUT = out_q;
endmodule

// File: tb/tb_dds_top.sv
// Self-checking bench for dds_top: fixed waveform tables, wrap/hold, reset, and
// randomized tuning/select against an arithmetic reference model.

module tb_dds_top;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tw  = '0;
  logic [2:0]  sel = '0;
  logic [13:0] phase_off = '0;
  logic [11:0] OUT;

  int errors = 0;
  int checks = 0;
  int racc   = 0;

  always #5 clk = ~clk;

  dds_top dut (
    .clk       (clk),
    .rst       (rst),
    .tuningW   (tw),
    .sel       (sel),
`ifdef DDS_PHASE_OFFSET_EN
    .phase_off (phase_off),
`endif
    .OUT       (OUT)
  );

  function automatic int off_now();
`ifdef DDS_PHASE_OFFSET_EN
    return int'(phase_off);
`else
    return 0;
`endif
  endfunction

  // Reference: expected sample for a given accumulator value, select and offset.
  function automatic logic [11:0] model_f(input int a, input int s, input int off);
    int p, h, x, y, amp, t, r;
    p = ((a / 4) + off) % 16384;
    h = p / 8192;
    x = p % 8192;
    case (s)
      0: begin
        y   = x * (8191 - x);
        amp = y / 8192;
        if (amp > 2047) amp = 2047;
        r = h ? 2048 - amp : 2048 + amp;
      end
      1: r = h ? 0 : 4095;
      2: r = p / 4;
      3: begin
        t = x / 2;
        r = h ? 4095 - t : t;
      end
      4: r = 4095 - p / 4;
      default: r = 2048;
    endcase
    return 12'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    racc = (racc + int'(tw)) % 65536;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    racc = 0;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    #3;
    checks++;
    if (OUT !== 12'h000) begin
      errors++;
      $display("FAIL reset_initial: got %h want 000", OUT);
    end
    rst = 1'b0;
    racc = 0;
    tw = 16'h1234;
    sel = 3'b000;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (OUT !== 12'h000) begin
      errors++;
      $display("FAIL reset_async: got %h want 000", OUT);
    end
    tick();
    checks++;
    if (OUT !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold: got %h want 000", OUT);
    end
    rst = 1'b0;
    racc = 0;
    exp = 12'd2048;
    tick();
    checks++;
    if (OUT !== exp) begin
      errors++;
      $display("FAIL reset_first_edge: got %h want %h", OUT, exp);
    end
  endtask

  task automatic test_patterns();
    logic [11:0] tbl [5][4];
    tbl[0] = '{12'd2048, 12'd4095, 12'd2048, 12'd1};
    tbl[1] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000};
    tbl[2] = '{12'h000, 12'h400, 12'h800, 12'hC00};
    tbl[3] = '{12'h000, 12'h800, 12'hFFF, 12'h7FF};
    tbl[4] = '{12'hFFF, 12'hBFF, 12'h7FF, 12'h3FF};
    for (int s = 0; s < 5; s++) begin
      do_reset();
      tw  = 16'h4000;
      sel = 3'(s);
      for (int i = 0; i < 8; i++) begin
        tick();
        checks++;
        if (OUT !== tbl[s][i % 4]) begin
          errors++;
          $display("FAIL pattern_sel%0d_step%0d: got %h want %h", s, i, OUT, tbl[s][i % 4]);
        end
      end
    end
  endtask

  task automatic test_wrap_hold();
    logic [11:0] want [2];
    want = '{12'hFFF, 12'h3FF};
    do_reset();
    tw  = 16'h3FFF;
    sel = 3'b010;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (OUT !== want[i]) begin
        errors++;
        $display("FAIL wrap_step%0d: got %h want %h", i, OUT, want[i]);
      end
    end
    tw = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (OUT !== 12'h7FF) begin
        errors++;
        $display("FAIL hold_step%0d: got %h want 7ff", i, OUT);
      end
    end
    for (int s = 5; s < 8; s++) begin
      sel = 3'(s);
      tw  = 16'(s * 16'h1111);
      tick();
      checks++;
      if (OUT !== 12'h800) begin
        errors++;
        $display("FAIL midscale_sel%0d: got %h want 800", s, OUT);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] exp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tw  = 16'($urandom);
      sel = 3'($urandom_range(0, 7));
`ifdef DDS_PHASE_OFFSET_EN
      phase_off = 14'($urandom);
`endif
      exp = model_f(racc, int'(sel), off_now());
      tick();
      checks++;
      if (OUT !== exp) begin
        errors++;
        $display("FAIL random_%0d: tw=%h sel=%0d got %h want %h", i, tw, sel, OUT, exp);
      end
    end
`ifdef DDS_PHASE_OFFSET_EN
    phase_off = '0;
`endif
  endtask

`ifdef DDS_PHASE_OFFSET_EN
  task automatic test_offset();
    do_reset();
    tw  = 16'h0000;
    sel = 3'b000;
    phase_off = 14'h1000;
    tick();
    checks++;
    if (OUT !== 12'd4095) begin
      errors++;
      $display("FAIL offset_1000: got %0d want 4095", OUT);
    end
    phase_off = 14'h3000;
    tick();
    checks++;
    if (OUT !== 12'd1) begin
      errors++;
      $display("FAIL offset_3000: got %0d want 1", OUT);
    end
    phase_off = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_patterns();
    test_wrap_hold();
    test_random();
`ifdef DDS_PHASE_OFFSET_EN
    test_offset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
